vector_reg_file: RTL and testbench
==================================

Name: vector_reg_file

Overview:
- Parametrised vector register file for the V-extension datapath; the vector counterpart of the scalar register file.
- Provides NREG registers of VLEN bits each, with three combinational read ports and a dedicated v0 mask output.
- One write port updates only active body elements, selected by element width (SEW), vector length (vl) and optional v0 masking.
- A sequenced clear engine zeroes the whole file on request without a full reset.

Parameters:
- NREG, 32, number of vector registers; power of 2, minimum 2.
- VLEN, 128, bits per register; multiple of 32, minimum 32.
- AW, $clog2(NREG), register address width; derived, not overridden.
- VLW, $clog2(VLEN/8)+1, vl width; derived.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- write  in  1  write request
- is_v  in  1  qualifies write as a vector destination; a write happens only when write & is_v & wr_ready
- wr_addr  in  AW  destination register
- wr_data  in  VLEN  write data, element-packed (element 0 in the LSBs)
- wr_sew  in  2  element width: 00=8, 01=16, 10=32, 11 reserved
- wr_vm  in  1  1 = unmasked; 0 = element i written only if v0[i]=1
- wr_vl  in  VLW  number of body elements; elements at index >= vl are tail and are left unchanged
- wr_ready  out  1  1 when writes are accepted
- clr_req  in  1  start clear sequence (single-cycle pulse)
- busy  out  1  clear sequence in progress
- vs1_addr, vs2_addr, vs3_addr  in  AW each  read addresses
- vs1_data, vs2_data, vs3_data  out  VLEN each  read data
- v0_data  out  VLEN  current contents of register 0

Behaviour:
- Reset (rst=1, asynchronous): all registers = 0; FSM = IDLE; busy = 0; wr_ready = 1; clear index = 0. All read outputs therefore show 0.
- Read ports are combinational from the array; there is no bypass. A write at edge N is visible on reads after edge N.
- Register 0 is writable. It is the mask source and is not hardwired to zero.
- Element count is NE = VLEN/SEW. Element i is written at a posedge iff:
  - write & is_v & wr_ready, and
  - i < min(wr_vl, NE), and
  - wr_vm = 1 or v0_data[i] = 1.
- Masking uses v0 as it is before the edge, including when wr_addr = 0.
- Non-written elements keep their old value: tail-undisturbed, mask-undisturbed.
- wr_vl > NE is clamped to NE. wr_vl = 0 writes nothing.
- wr_sew = 11 writes nothing.
- FSM states:
  - IDLE: wr_ready = 1, busy = 0. clr_req moves to CLEAR with idx = 0 at the next edge.
  - CLEAR: wr_ready = 0, busy = 1. Each cycle x[idx] <= 0 and idx++. When idx = NREG-1 is cleared, return to IDLE. The sequence takes exactly NREG cycles.
- Simultaneous clr_req and write in IDLE: the write is performed that edge, then CLEAR starts. The cleared file therefore ends all-zero.
- clr_req during CLEAR is ignored; the sequence does not restart.
- Writes presented while wr_ready = 0 are dropped. The upstream must hold them.
- rst asserted mid-CLEAR: immediately all zero, IDLE, busy = 0.
- No X propagation from out-of-range vl; all index comparisons are unsigned.

Test Plan:
- Reset and readback: assert rst, release, read all 32 registers on vs1/vs2/vs3 -> all 0; wr_ready=1, busy=0.
- Full write: SEW=32, vm=1, vl=4, wr_addr=5, data=0x44444444_33333333_22222222_11111111. Then vs2_addr=5 -> same value. Repeat with is_v=0 -> register 5 unchanged.
- Tail and clamp behaviour:
  - Register 7 preloaded with all 0xFF. Write SEW=8, vl=3, data=0 -> vs1 = 0xFF..FF_000000 (low 3 bytes cleared).
  - vl=20 with SEW=32 -> all 4 words written.
  - vl=0 -> no change.
- Masked write: v0 = 0x...0005. Write SEW=16, vm=0, vl=8, addr 3, data all 0xAAAA, reg 3 preloaded 0 -> elements 0 and 2 = 0xAAAA, all others 0. Also write addr 0 with vm=0 -> masking uses the old v0.
- Clear sequence:
  - Fill registers with nonzero values, pulse clr_req -> busy=1 and wr_ready=0 for exactly 32 cycles, then all registers read 0.
  - A write during busy is dropped.
  - A second clr_req mid-sequence does not extend it.
- Reset mid-clear: at clear cycle 10, assert rst asynchronously (off clock edge) -> busy falls without waiting for a clock, all registers 0; after release, normal writes work.

Source files
------------

// File: rtl/vector_reg_file.sv
// Vector register file: NREG x VLEN array with three combinational read ports and a v0 mask tap.
// The write port honours SEW, vl and the v0 mask; a sequenced engine clears one register per cycle.

module vrf_lane_en #(
    parameter int VLW  = 5,
    parameter int LANE = 0
) (
    input  logic [1:0]     sew_i,
    input  logic           vm_i,
    input  logic [VLW-1:0] vl_i,
    input  logic [2:0]     mask_i,  // {v0[LANE/4], v0[LANE/2], v0[LANE]}
    output logic           en_o
);
    // Index of the element that owns this byte, for each element width.
    localparam logic [VLW-1:0] E8  = VLW'(LANE);
    localparam logic [VLW-1:0] E16 = VLW'(LANE / 2);
    localparam logic [VLW-1:0] E32 = VLW'(LANE / 4);

    always_comb begin
        en_o = 1'b0;
        case (sew_i)
            2'b00:   en_o = (E8  < vl_i) & (vm_i | mask_i[0]);
            2'b01:   en_o = (E16 < vl_i) & (vm_i | mask_i[1]);
            2'b10:   en_o = (E32 < vl_i) & (vm_i | mask_i[2]);
            default: en_o = 1'b0;
        endcase
    end
endmodule

module vector_reg_file #(
    parameter int NREG = 32,
    parameter int VLEN = 128,
    parameter int AW   = $clog2(NREG),
    parameter int VLW  = $clog2(VLEN / 8) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write,
    input  logic            is_v,
    input  logic [AW-1:0]   wr_addr,
    input  logic [VLEN-1:0] wr_data,
    input  logic [1:0]      wr_sew,
    input  logic            wr_vm,
    input  logic [VLW-1:0]  wr_vl,
    output logic            wr_ready,
    input  logic            clr_req,
    output logic            busy,
    input  logic [AW-1:0]   vs1_addr,
    input  logic [AW-1:0]   vs2_addr,
    input  logic [AW-1:0]   vs3_addr,
    output logic [VLEN-1:0] vs1_data,
    output logic [VLEN-1:0] vs2_data,
    output logic [VLEN-1:0] vs3_data,
    output logic [VLEN-1:0] v0_data
);
    localparam int NB = VLEN / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                     state_q;
    logic                       busy_q, wr_ready_q;
    logic [AW-1:0]              idx_q;
    logic [NREG-1:0][VLEN-1:0]  regs_q, regs_d;
    logic [NB-1:0]              ben;
    logic                       we;

    assign we       = write & is_v & wr_ready_q;
    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign vs1_data = regs_q[vs1_addr];
    assign vs2_data = regs_q[vs2_addr];
    assign vs3_data = regs_q[vs3_addr];
    assign v0_data  = regs_q[0];

    // Byte granularity covers every legal SEW; each byte sees the mask bit of its element.
    for (genvar b = 0; b < NB; b++) begin : g_lane
        vrf_lane_en #(.VLW(VLW), .LANE(b)) u_en (
            .sew_i  (wr_sew),
            .vm_i   (wr_vm),
            .vl_i   (wr_vl),
            .mask_i ({v0_data[b/4], v0_data[b/2], v0_data[b]}),
            .en_o   (ben[b])
        );
    end

    always_comb begin
        regs_d = regs_q;
        for (int b = 0; b < NB; b++) begin
            if (we && ben[b]) regs_d[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        end
        if (state_q == CLEAR) regs_d[idx_q] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    // A write coinciding with clr_req in IDLE lands first; the sweep then zeroes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            idx_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q    <= CLEAR;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                        idx_q      <= '0;
                    end
                end
                CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == AW'(NREG - 1)) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        wr_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_reg_file.sv
// Scoreboard bench for vector_reg_file: the driver pushes expected read/status values from a
// plain array model each cycle; a negedge monitor pops and compares against the DUT.

module tb_vector_reg_file;
    localparam int NREG = 32;
    localparam int VLEN = 128;
    localparam int AW   = $clog2(NREG);
    localparam int VLW  = $clog2(VLEN / 8) + 1;

    logic            clk, rst;
    logic            write, is_v, wr_vm, clr_req;
    logic [AW-1:0]   wr_addr, vs1_addr, vs2_addr, vs3_addr;
    logic [VLEN-1:0] wr_data;
    logic [1:0]      wr_sew;
    logic [VLW-1:0]  wr_vl;
    logic            wr_ready, busy;
    logic [VLEN-1:0] vs1_data, vs2_data, vs3_data, v0_data;

    vector_reg_file #(.NREG(NREG), .VLEN(VLEN)) dut (
        .clk(clk), .rst(rst), .write(write), .is_v(is_v), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_sew(wr_sew), .wr_vm(wr_vm), .wr_vl(wr_vl),
        .wr_ready(wr_ready), .clr_req(clr_req), .busy(busy),
        .vs1_addr(vs1_addr), .vs2_addr(vs2_addr), .vs3_addr(vs3_addr),
        .vs1_data(vs1_data), .vs2_data(vs2_data), .vs3_data(vs3_data), .v0_data(v0_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [VLEN-1:0] d1, d2, d3, v0;
        logic            busy, rdy;
    } exp_t;

    exp_t            sb[$];
    logic            chk_vld = 1'b0;
    int              checks = 0, errors = 0;

    // Reference model: architectural register contents plus clear progress.
    logic [VLEN-1:0] mdl [NREG];
    bit              m_busy;
    int              m_idx;

    task automatic cmp(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_vld) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty @%0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                cmp("vs1", vs1_data, e.d1);
                cmp("vs2", vs2_data, e.d2);
                cmp("vs3", vs3_data, e.d3);
                cmp("v0",  v0_data,  e.v0);
                cmp("busy", VLEN'(busy), VLEN'(e.busy));
                cmp("wr_ready", VLEN'(wr_ready), VLEN'(e.rdy));
            end
        end
    end

    task automatic mdl_reset();
        for (int r = 0; r < NREG; r++) mdl[r] = '0;
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    // Element i of width s bits occupies bits [i*s +: s]; mask bit i comes from old v0.
    task automatic mdl_write(input int a, input logic [VLEN-1:0] d, input int sew,
                             input bit vm, input int vl);
        int s, ne, n;
        logic [VLEN-1:0] v0old;
        if (sew == 3) return;
        s     = 8 << sew;
        ne    = VLEN / s;
        n     = (vl < ne) ? vl : ne;
        v0old = mdl[0];
        for (int i = 0; i < n; i++)
            if (vm || v0old[i])
                for (int k = 0; k < s; k++) mdl[a][i*s + k] = d[i*s + k];
    endtask

    task automatic push_exp();
        exp_t e;
        e.d1 = mdl[vs1_addr]; e.d2 = mdl[vs2_addr]; e.d3 = mdl[vs3_addr];
        e.v0 = mdl[0]; e.busy = m_busy; e.rdy = !m_busy;
        sb.push_back(e);
        chk_vld = 1'b1;
    endtask

    // Called at posedge+1 with inputs set; checks this cycle, then advances the model one edge.
    task automatic tick();
        push_exp();
        if (write && is_v && !m_busy)
            mdl_write(int'(wr_addr), wr_data, int'(wr_sew), wr_vm, int'(wr_vl));
        if (m_busy) begin
            mdl[m_idx] = '0;
            m_idx++;
            if (m_idx == NREG) m_busy = 1'b0;
        end else if (clr_req) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end
        @(posedge clk); #1;
        chk_vld = 1'b0; write = 1'b0; clr_req = 1'b0; is_v = 1'b1;
    endtask

    task automatic rnd_rd();
        vs1_addr = AW'($urandom); vs2_addr = AW'($urandom); vs3_addr = AW'($urandom);
    endtask

    task automatic wr(input int a, input logic [VLEN-1:0] d, input int sew, input bit vm, input int vl);
        write = 1'b1; wr_addr = AW'(a); wr_data = d; wr_sew = 2'(sew); wr_vm = vm; wr_vl = VLW'(vl);
    endtask

    task automatic rd(input int a);
        vs1_addr = AW'(a); vs2_addr = AW'(a); vs3_addr = AW'(a);
    endtask

    function automatic logic [VLEN-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            wr($urandom_range(1, NREG-1), rnd_vec(), 2, 1'b1, 4);
            rnd_rd();
            tick();
        end
    endtask

    task automatic async_rst();
        #1 rst = 1'b1;
        mdl_reset();
        rnd_rd();
        push_exp();
        @(posedge clk); #1;
        chk_vld = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; is_v = 1'b1; wr_vm = 1'b1; clr_req = 1'b0;
        wr_addr = '0; wr_data = '0; wr_sew = 2'b10; wr_vl = '0;
        vs1_addr = '0; vs2_addr = '0; vs3_addr = '0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset readback across all registers
        for (int r = 0; r < NREG; r++) begin
            vs1_addr = AW'(r); vs2_addr = AW'((r + 1) % NREG); vs3_addr = AW'(NREG - 1 - r);
            tick();
        end

        // Full SEW=32 write, then is_v=0 must not touch it
        wr(5, 128'h44444444_33333333_22222222_11111111, 2, 1'b1, 4); tick();
        rd(5); tick();
        wr(5, rnd_vec(), 2, 1'b1, 4); is_v = 1'b0; tick();
        rd(5); tick();

        // Tail undisturbed, clamp, vl=0
        wr(7, {VLEN{1'b1}}, 2, 1'b1, 4); tick();
        wr(7, '0, 0, 1'b1, 3); tick();
        rd(7); tick();
        wr(8, rnd_vec(), 2, 1'b1, 20); tick();
        rd(8); tick();
        wr(8, rnd_vec(), 2, 1'b1, 0); tick();
        rd(8); tick();
        wr(8, rnd_vec(), 3, 1'b1, 16); tick();
        rd(8); tick();

        // Masked writes with v0 = 5, including a masked write to v0 itself
        wr(0, 128'h5, 2, 1'b1, 4); tick();
        wr(3, {8{16'hAAAA}}, 1, 1'b0, 8); tick();
        rd(3); tick();
        wr(0, {VLEN{1'b1}}, 0, 1'b0, 16); tick();
        rd(0); tick();

        // Clear with coincident write, dropped write and a second clr_req mid-sweep
        fill_random(20);
        wr(9, rnd_vec(), 2, 1'b1, 4); clr_req = 1'b1; rnd_rd(); tick();
        for (int c = 0; c < NREG + 3; c++) begin
            rnd_rd();
            if (c == 5)  wr(NREG-1, rnd_vec(), 2, 1'b1, 4);
            if (c == 12) clr_req = 1'b1;
            tick();
        end
        for (int r = 0; r < NREG; r++) begin rd(r); tick(); end

        // Asynchronous reset at clear cycle 10
        fill_random(10);
        clr_req = 1'b1; rnd_rd(); tick();
        for (int c = 0; c < 10; c++) begin rnd_rd(); tick(); end
        async_rst();
        for (int r = 0; r < NREG; r++) begin rd(r); tick(); end
        wr(4, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 2, 1'b1, 4); tick();
        rd(4); tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rnd_rd();
            if ($urandom_range(0, 3) != 0)
                wr(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, NREG-1), rnd_vec(),
                   $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 31));
            is_v = ($urandom_range(0, 7) != 0);
            clr_req = ($urandom_range(0, 99) == 0);
            tick();
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
